// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer geometry and Gray-code conversions.
// Both the write-side and read-side controllers import this package.
package fifo_pkg;

    localparam int PTR_WIDTH = 3;
    localparam int DEPTH     = 2 ** PTR_WIDTH;

    typedef logic [PTR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[PTR_WIDTH] = gray[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side FIFO control bundle: producer request, read-pointer input,
// and the write controller's pointers and status flags.
interface fifo_wr_ctrl_if #(
    parameter int PTR_WIDTH = fifo_pkg::PTR_WIDTH
);
    logic                 w_en;
    logic [PTR_WIDTH:0]   g_rptr_async;
    logic                 ovf_clr;
    logic [PTR_WIDTH:0]   b_wptr;
    logic [PTR_WIDTH:0]   g_wptr;
    logic                 full;
    logic                 almost_full;
    logic [PTR_WIDTH:0]   wr_level;
    logic                 wr_ack;
    logic                 overflow;

    modport master (
        output w_en, g_rptr_async, ovf_clr,
        input  b_wptr, g_wptr, full, almost_full, wr_level, wr_ack, overflow
    );

    modport slave (
        input  w_en, g_rptr_async, ovf_clr,
        output b_wptr, g_wptr, full, almost_full, wr_level, wr_ack, overflow
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing a Gray-coded pointer into the wclk domain.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments make q take meta's old value, giving two real stages.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of an asynchronous FIFO: write pointer, full and
// almost-full detection against the synchronized read pointer, overflow flag.
module fifo_wr_ctrl
    import fifo_pkg::bin2gray, fifo_pkg::gray2bin;
#(
    parameter int DEPTH     = fifo_pkg::DEPTH,
    parameter int PTR_WIDTH = fifo_pkg::PTR_WIDTH,
    parameter int AF_LEVEL  = 6
) (
    input  logic          wclk,
    input  logic          wrst_n,
    fifo_wr_ctrl_if.slave wif
);
    // An out-of-range AF_LEVEL saturates at DEPTH rather than never firing.
    localparam int                 AF_CLAMP  = (AF_LEVEL > DEPTH) ? DEPTH : AF_LEVEL;
    localparam logic [PTR_WIDTH:0] AF_THRESH = (PTR_WIDTH + 1)'(AF_CLAMP);

    logic [PTR_WIDTH:0] g_rptr_sync;
    logic [PTR_WIDTH:0] b_wptr, g_wptr, wr_level;
    logic [PTR_WIDTH:0] b_wptr_next, g_wptr_next, wr_level_next;
    logic               full, almost_full, wr_ack, overflow;
    logic               wr_accept, full_next, almost_full_next, overflow_next;

    sync_2ff #(.WIDTH(PTR_WIDTH + 1)) u_rptr_sync (
        .wclk  (wclk),
        .wrst_n(wrst_n),
        .d     (wif.g_rptr_async),
        .q     (g_rptr_sync)
    );

    always_comb begin
        wr_accept        = wif.w_en && !full;
        b_wptr_next      = b_wptr + {{PTR_WIDTH{1'b0}}, wr_accept};
        g_wptr_next      = bin2gray(b_wptr_next);
        // Full: writer is one lap ahead, i.e. Gray pointers differ only in the top two bits.
        full_next        = (g_wptr_next == {~g_rptr_sync[PTR_WIDTH -: 2],
                                            g_rptr_sync[PTR_WIDTH-2:0]});
        wr_level_next    = b_wptr_next - gray2bin(g_rptr_sync);
        almost_full_next = (wr_level_next >= AF_THRESH);
        overflow_next    = (wif.w_en && full) || (overflow && !wif.ovf_clr);
    end

    // NOTE: reset has priority over everything, so w_en is ignored in a reset cycle.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            wr_level    <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_ack      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= b_wptr_next;
            g_wptr      <= g_wptr_next;
            wr_level    <= wr_level_next;
            full        <= full_next;
            almost_full <= almost_full_next;
            wr_ack      <= wr_accept;
            overflow    <= overflow_next;
        end
    end

    assign wif.b_wptr      = b_wptr;
    assign wif.g_wptr      = g_wptr;
    assign wif.wr_level    = wr_level;
    assign wif.full        = full;
    assign wif.almost_full = almost_full;
    assign wif.wr_ack      = wr_ack;
    assign wif.overflow    = overflow;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: directed scenarios then random traffic,
// checked against a counting model of writes, reads and synchronizer delay.
module tb_fifo_wr_ctrl;
    localparam int PW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    typedef struct packed {
        logic [3:0] b_wptr;
        logic [3:0] g_wptr;
        logic [3:0] wr_level;
        logic       full;
        logic       almost_full;
        logic       wr_ack;
        logic       overflow;
    } exp_t;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b0;
    always #5 wclk = ~wclk;

    fifo_wr_ctrl_if #(.PTR_WIDTH(PW)) wif ();

    fifo_wr_ctrl #(.DEPTH(DEPTH), .PTR_WIDTH(PW), .AF_LEVEL(AF)) dut (
        .wclk  (wclk),
        .wrst_n(wrst_n),
        .wif   (wif)
    );

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model: total writes accepted since reset, read counts seen by the two sync stages.
    int   m_wr = 0, m_s1 = 0, m_s2 = 0;
    bit   m_full = 0, m_ovf = 0;
    int   rd_cnt = 0;

    // Monitor-side bookkeeping used by the directed scenarios.
    int         ack_seen = 0, full_seen = 0;
    bit         wrap_b = 0, wrap_g = 0;
    logic [3:0] prev_b = '0, prev_g = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] gray4(input int v);
        logic [3:0] b;
        b = 4'(v);
        return b ^ (b >> 1);
    endfunction

    // One wclk cycle: drive at the falling edge, predict, return just after the rising edge.
    task automatic step(input bit we, input bit clr, input bit rst);
        exp_t e;
        int   lvl;
        bit   acc;
        @(negedge wclk);
        wif.w_en         = we;
        wif.ovf_clr      = clr;
        wrst_n           = !rst;
        wif.g_rptr_async = gray4(rd_cnt);
        if (rst) begin
            m_wr = 0; m_s1 = 0; m_s2 = 0; m_full = 0; m_ovf = 0;
            acc  = 0; lvl = 0;
        end else begin
            acc    = we && !m_full;
            m_ovf  = (we && m_full) || (m_ovf && !clr);
            m_wr   = m_wr + int'(acc);
            lvl    = m_wr - m_s2;
            m_full = (lvl >= DEPTH);
            m_s2   = m_s1;
            m_s1   = rd_cnt;
        end
        e.b_wptr      = 4'(m_wr);
        e.g_wptr      = gray4(m_wr);
        e.wr_level    = 4'(lvl);
        e.full        = m_full;
        e.almost_full = (lvl >= AF);
        e.wr_ack      = acc;
        e.overflow    = m_ovf;
        exp_q.push_back(e);
        @(posedge wclk);
        #2;
    endtask

    always begin
        @(posedge wclk);
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("b_wptr",      32'(wif.b_wptr),      32'(mon_e.b_wptr));
            check("g_wptr",      32'(wif.g_wptr),      32'(mon_e.g_wptr));
            check("wr_level",    32'(wif.wr_level),    32'(mon_e.wr_level));
            check("full",        32'(wif.full),        32'(mon_e.full));
            check("almost_full", 32'(wif.almost_full), 32'(mon_e.almost_full));
            check("wr_ack",      32'(wif.wr_ack),      32'(mon_e.wr_ack));
            check("overflow",    32'(wif.overflow),    32'(mon_e.overflow));
            if (wif.wr_ack === 1'b1) ack_seen++;
            if (wif.full === 1'b1) full_seen++;
            if (prev_b == 4'b1111 && wif.b_wptr == 4'b0000) wrap_b = 1;
            if (prev_g == 4'b1000 && wif.g_wptr == 4'b0000) wrap_g = 1;
            prev_b = wif.b_wptr;
            prev_g = wif.g_wptr;
        end
    end

    initial begin
        int ack0;
        bit we, clr, rst;
        wif.w_en         = 1'b1;
        wif.ovf_clr      = 1'b0;
        wif.g_rptr_async = '0;

        // Reset held for two edges with w_en high.
        step(1, 0, 1);
        step(1, 0, 1);
        step(0, 0, 0);
        check("rst_b_wptr",   32'(wif.b_wptr),   32'd0);
        check("rst_wr_level", 32'(wif.wr_level), 32'd0);
        check("rst_overflow", 32'(wif.overflow), 32'd0);

        // Fill with the read pointer parked at zero.
        ack0 = ack_seen;
        repeat (8) step(1, 0, 0);
        check("fill_b_wptr",   32'(wif.b_wptr),   32'b1000);
        check("fill_g_wptr",   32'(wif.g_wptr),   32'b1100);
        check("fill_full",     32'(wif.full),     32'd1);
        check("fill_wr_level", 32'(wif.wr_level), 32'd8);
        check("fill_acks",     32'(ack_seen - ack0), 32'd8);

        // Overflow, set-wins against clear, then clear alone.
        step(1, 0, 0);
        check("ovf_set",    32'(wif.overflow), 32'd1);
        check("ovf_b_wptr", 32'(wif.b_wptr),   32'b1000);
        step(1, 1, 0);
        check("ovf_setwins", 32'(wif.overflow), 32'd1);
        step(0, 1, 0);
        check("ovf_clear", 32'(wif.overflow), 32'd0);

        // Drain one entry: full drops on the third edge.
        rd_cnt = 1;
        step(0, 0, 0);
        step(0, 0, 0);
        check("drain_full_edge2", 32'(wif.full), 32'd1);
        step(0, 0, 0);
        check("drain_full_edge3", 32'(wif.full),        32'd0);
        check("drain_level",      32'(wif.wr_level),    32'd7);
        check("drain_af",         32'(wif.almost_full), 32'd1);

        // Refill, overflow, then reset mid-operation.
        step(1, 0, 0);
        step(1, 0, 0);
        check("pre_rst_full", 32'(wif.full),     32'd1);
        check("pre_rst_ovf",  32'(wif.overflow), 32'd1);
        rd_cnt = 0;
        step(1, 0, 1);
        check("midrst_full",   32'(wif.full),     32'd0);
        check("midrst_ovf",    32'(wif.overflow), 32'd0);
        check("midrst_b_wptr", 32'(wif.b_wptr),   32'd0);
        step(1, 0, 0);
        check("post_rst_b_wptr", 32'(wif.b_wptr), 32'd1);
        check("post_rst_ack",    32'(wif.wr_ack), 32'd1);

        // Wrap: read pointer trails two behind the write count.
        full_seen = 0; wrap_b = 0; wrap_g = 0;
        repeat (20) begin
            rd_cnt = (m_wr >= 2) ? m_wr - 2 : 0;
            step(1, 0, 0);
        end
        check("wrap_b_wptr",  32'(wrap_b),    32'd1);
        check("wrap_g_wptr",  32'(wrap_g),    32'd1);
        check("wrap_no_full", 32'(full_seen), 32'd0);

        // Random traffic: reads never pass committed writes.
        repeat (400) begin
            we  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 99) == 0);
            if (rst) rd_cnt = 0;
            else if (rd_cnt < m_wr && $urandom_range(0, 1) == 1) rd_cnt++;
            step(we, clr, rst);
        end

        step(0, 0, 0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: number of FIFO entries; SHALL be 2**PTR_WIDTH.
REQ-002 Parameter PTR_WIDTH, default 3: memory address width; pointers are PTR_WIDTH+1 bits, with the MSB as the wrap bit.
REQ-003 Parameter AF_LEVEL, default 6: fill level at or above which almost_full asserts; range 1..DEPTH.
REQ-004 Port wclk, input, 1: write-domain clock; all flops sample on the rising edge.
REQ-005 Port wrst_n, input, 1: reset; synchronous, active-low.
REQ-006 Port w_en, input, 1: write request from the producer.
REQ-007 Port g_rptr_async, input, PTR_WIDTH+1: Gray-coded read pointer, launched from the rclk domain.
REQ-008 Port ovf_clr, input, 1: clears the sticky overflow flag.
REQ-009 Port b_wptr, output, PTR_WIDTH+1: binary write pointer; bits [PTR_WIDTH-1:0] drive the memory write address.
REQ-010 Port g_wptr, output, PTR_WIDTH+1: Gray write pointer, for transfer to the read domain.
REQ-011 Port full, output, 1: FIFO full, registered.
REQ-012 Port almost_full, output, 1: fill level >= AF_LEVEL, registered.
REQ-013 Port wr_level, output, PTR_WIDTH+1: conservative fill level, range 0..DEPTH.
REQ-014 Port wr_ack, output, 1: one-cycle pulse, asserted the cycle after an accepted write.
REQ-015 Port overflow, output, 1: sticky flag, set by a write attempted while full.

Function
REQ-016 A write is accepted in a cycle when w_en=1 and full=0 at the rising edge of wclk. This is the same condition the memory uses to store data.
- On an accepted write: b_wptr_next = b_wptr+1, modulo 2**(PTR_WIDTH+1).
- Otherwise: b_wptr_next = b_wptr.
REQ-017 g_wptr SHALL be registered as bin2gray(b_wptr_next), updated on the same edge as b_wptr. It SHALL never be derived combinationally from b_wptr.
REQ-018 g_rptr_async SHALL pass through a 2-flop synchronizer to produce g_rptr_sync. This gives 2 wclk edges of latency.
REQ-019 full_next SHALL be 1 when bin2gray(b_wptr_next) equals g_rptr_sync with its two MSBs inverted and its remaining bits equal. It is re-evaluated every cycle, including cycles with no write.
REQ-020 wr_level SHALL be registered as (b_wptr_next - gray2bin(g_rptr_sync)), modulo 2**(PTR_WIDTH+1).
REQ-021 almost_full SHALL be registered as (wr_level_next >= AF_LEVEL).
REQ-022 A write attempted while full (w_en=1, full=1):
- SHALL leave b_wptr, g_wptr and wr_level unchanged;
- SHALL NOT assert wr_ack;
- SHALL set overflow on the next edge.
REQ-023 overflow SHALL remain set until ovf_clr=1 or reset. If ovf_clr=1 and a new overflow occur in the same cycle, set wins.
REQ-024 Pointer wrap-around from 2**(PTR_WIDTH+1)-1 to 0 SHALL occur without any glitch in full or wr_level.
REQ-025 A read-pointer advance SHALL deassert full on the 3rd wclk edge after g_rptr_async changes.

Reset
REQ-026 While wrst_n=0 at an edge, the following SHALL be cleared to 0: b_wptr, g_wptr, both synchronizer stages, full, almost_full, wr_level, wr_ack and overflow. w_en SHALL be ignored during that cycle.
REQ-027 A reset asserted mid-operation, including while full=1 and overflow=1, SHALL take effect on the next edge with no residual state.

Structure
REQ-028 Package fifo_pkg SHALL hold the bin2gray and gray2bin functions and the shared DEPTH/PTR_WIDTH localparams. The read-side controller reuses this package.
REQ-029 The synchronizer SHALL be a separate sub-module, sync_2ff, with parameter WIDTH and ports wclk, wrst_n, d and q. Its reset behaviour matches REQ-026.

Verification
REQ-030 The bench SHALL cover the following directed scenarios (DEPTH=8, AF_LEVEL=6):
- Reset: wrst_n=0 for 2 edges with w_en=1 -> all outputs 0 after release.
- Fill: g_rptr_async=0, then 8 consecutive w_en -> b_wptr=4'b1000, g_wptr=4'b1100, full=1, wr_level=8. wr_ack pulses 8 times, and almost_full rises on the edge where wr_level becomes 6.
- Overflow: from full, one extra w_en -> pointers unchanged, overflow=1. Then ovf_clr=1 together with w_en=1 -> overflow stays 1. ovf_clr=1 alone -> overflow=0.
- Drain: from full, g_rptr_async=4'b0001 -> full=0 and wr_level=7 on the 3rd wclk edge. almost_full stays 1.
- Wrap: 16 writes with the read pointer tracking 2 behind -> b_wptr passes 4'b1111 to 4'b0000, g_wptr passes 4'b1000 to 4'b0000, and full is never asserted.
- Mid-op reset: wrst_n=0 for 1 edge while full=1 and overflow=1 -> all outputs 0 on that edge. The first write after reset is accepted.
